// File: rtl/i2s_pkg.sv
// Shared I2S frame constants and lock-state encoding, common to the clock master and follower.
package i2s_pkg;

    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned HALF_FRAME = 32;
    localparam int unsigned POSN_W     = 6;

    typedef logic [POSN_W-1:0] posn_t;

    typedef enum logic [1:0] {
        ST_UNALIGNED,
        ST_ALIGNED,
        ST_LOCKED
    } lock_state_t;

    // Frame position constant truncated to the counter width
    function automatic posn_t posn_const(input int unsigned v);
        return posn_t'(v);
    endfunction

    localparam posn_t POSN_LAST = posn_const(FRAME_BITS - 1);
    localparam posn_t POSN_HALF = posn_const(HALF_FRAME);

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer for one asynchronous I2S line, plus a history flop and
// registered rise/fall strobes. o_level is the history flop, so it lines up with the strobes.
module i2s_edge_sync
    import i2s_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_ck,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Synchronize the input, keep one cycle of history and register the edge strobes
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= w_synced;
            r_rise <= w_synced & ~r_hist;
            r_fall <= ~w_synced & r_hist;
        end
    end

    assign o_level = r_hist;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2s_clock_follower.sv
// I2S clock follower: recovers the 64-bit L/R frame position from an externally
// mastered sck/ws pair, checks frame structure and reports lock.
// Optional feature macro: I2S_FOLLOWER_TIMEOUT_EN (idle-sck timeout drops lock and alignment).
module i2s_clock_follower
    import i2s_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              i_ck,
    input  logic              i_rst,
    input  logic              i_sck_in,
    input  logic              i_ws_in,
    output logic              o_sck_rise,
    output logic              o_sck_fall,
    output logic              o_ws,
    output logic [POSN_W-1:0] o_frame_posn,
    output logic              o_frame_start,
    output logic              o_locked,
    output logic              o_error
);

    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_sck_level_unused;
    logic        w_ws_level;
    logic        w_ws_rise_unused;
    logic        w_ws_fall_unused;

    logic        r_sck_rise;
    logic        r_sck_fall;
    logic        r_ws;
    posn_t       r_posn;
    logic        r_frame_start;
    logic        r_locked;
    logic        r_error;
    lock_state_t r_state;
    logic [3:0]  r_count;
    logic        r_saw_half;
    logic        r_resync;

    posn_t       w_posn_inc;
    logic        w_ws_fall;
    logic        w_ws_rise;
    logic        w_checking;
    logic        w_violation;
    logic        w_good;
    logic [3:0]  w_count_next;

`ifdef I2S_FOLLOWER_TIMEOUT_EN
    logic [7:0]  r_idle;
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;
`endif

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .i_ck    (i_ck),
        .i_rst   (i_rst),
        .i_async (i_sck_in),
        .o_level (w_sck_level_unused),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ws_sync (
        .i_ck    (i_ck),
        .i_rst   (i_rst),
        .i_async (i_ws_in),
        .o_level (w_ws_level),
        .o_rise  (w_ws_rise_unused),
        .o_fall  (w_ws_fall_unused)
    );

    assign w_posn_inc   = r_posn + 1'b1;
    assign w_ws_fall    = r_ws & ~w_ws_level;
    assign w_ws_rise    = ~r_ws & w_ws_level;
    assign w_checking   = (r_state != ST_UNALIGNED) && !r_resync;
    assign w_violation  = w_checking && (
                              (w_ws_fall && (r_posn != POSN_LAST)) ||
                              (w_ws_rise && (w_posn_inc != POSN_HALF)) ||
                              (!w_ws_fall && (r_posn == POSN_LAST)));
    assign w_good       = w_checking && w_ws_fall && (r_posn == POSN_LAST) && r_saw_half;
    assign w_count_next = (r_count == 4'hF) ? r_count : r_count + 4'd1;

    // Frame counter, framing checker and lock FSM, all advanced on synchronized sck rise
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_sck_rise    <= 1'b0;
            r_sck_fall    <= 1'b0;
            r_ws          <= 1'b0;
            r_posn        <= '0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_error       <= 1'b0;
            r_state       <= ST_UNALIGNED;
            r_count       <= '0;
            r_saw_half    <= 1'b0;
            r_resync      <= 1'b0;
`ifdef I2S_FOLLOWER_TIMEOUT_EN
            r_idle        <= '0;
`endif
        end else begin
            r_sck_rise    <= w_sck_rise;
            r_sck_fall    <= w_sck_fall;
            r_frame_start <= 1'b0;
            r_error       <= 1'b0;
            if (w_sck_rise) begin
                r_ws          <= w_ws_level;
                r_posn        <= w_ws_fall ? '0 : w_posn_inc;
                r_frame_start <= w_ws_fall;
                if (w_violation) begin
                    r_error    <= 1'b1;
                    r_locked   <= 1'b0;
                    r_state    <= ST_ALIGNED;
                    r_count    <= '0;
                    r_saw_half <= 1'b0;
                    // A violation on a 1->0 edge has already realigned the counter;
                    // any other violation suppresses checks until the next 1->0 edge.
                    r_resync   <= ~w_ws_fall;
                end else if (w_ws_fall) begin
                    r_saw_half <= 1'b0;
                    r_resync   <= 1'b0;
                    if (r_state == ST_UNALIGNED) begin
                        r_state <= ST_ALIGNED;
                    end else if (w_good) begin
                        r_count <= w_count_next;
                        if (w_count_next >= 4'(LOCK_FRAMES)) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end else if (w_ws_rise && w_checking) begin
                    r_saw_half <= 1'b1;
                end
            end
`ifdef I2S_FOLLOWER_TIMEOUT_EN
            if (w_sck_rise || w_sck_fall) begin
                r_idle <= '0;
            end else if (r_idle != 8'hFF) begin
                r_idle <= r_idle + 8'd1;
                if (r_idle == 8'(TIMEOUT - 1)) begin
                    r_error    <= 1'b1;
                    r_locked   <= 1'b0;
                    r_state    <= ST_UNALIGNED;
                    r_count    <= '0;
                    r_saw_half <= 1'b0;
                    r_resync   <= 1'b0;
                end
            end
`endif
        end
    end

    assign o_sck_rise    = r_sck_rise;
    assign o_sck_fall    = r_sck_fall;
    assign o_ws          = r_ws;
    assign o_frame_posn  = r_posn;
    assign o_frame_start = r_frame_start;
    assign o_locked      = r_locked;
    assign o_error       = r_error;

endmodule

// File: tb/tb_i2s_clock_follower.sv
// Directed bench for i2s_clock_follower: a bench-side I2S master drives sck/ws,
// pushes the expected follower state per sck rise, and a monitor pops and compares.
`timescale 1ns/1ps
module tb_i2s_clock_follower;

    localparam int unsigned SS   = 2;
    localparam int unsigned LF   = 2;
    localparam int          HALF = 6;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       sck_in = 1'b0;
    logic       ws_in = 1'b0;
    logic       sck_rise, sck_fall, ws, frame_start, locked, error;
    logic [5:0] frame_posn;

    always #5 ck = ~ck;

    i2s_clock_follower #(.SYNC_STAGES(SS), .LOCK_FRAMES(LF), .TIMEOUT(255)) dut (
        .i_ck          (ck),
        .i_rst         (rst),
        .i_sck_in      (sck_in),
        .i_ws_in       (ws_in),
        .o_sck_rise    (sck_rise),
        .o_sck_fall    (sck_fall),
        .o_ws          (ws),
        .o_frame_posn  (frame_posn),
        .o_frame_start (frame_start),
        .o_locked      (locked),
        .o_error       (error)
    );

    typedef struct {
        logic [5:0] posn;
        logic       ws;
        logic       fs;
        logic       lk;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fall_drv = 0;
    int   n_fall_seen = 0;
    int   n_err_pulses = 0;
    int   exp_err_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sck_rise"}, sck_rise, 0);
        check({tag, "_sck_fall"}, sck_fall, 0);
        check({tag, "_ws"}, ws, 0);
        check({tag, "_posn"}, frame_posn, 0);
        check({tag, "_fstart"}, frame_start, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // One sck bit: falling half with the new ws value, then the rising half
    task automatic bit_rise(input logic wsv, input int ep, input logic efs,
                            input logic elk, input logic eerr);
        exp_t e;
        if (sck_in) n_fall_drv++;
        sck_in = 1'b0;
        ws_in  = wsv;
        tick(HALF);
        sck_in = 1'b1;
        e.posn = 6'(ep);
        e.ws   = wsv;
        e.fs   = efs;
        e.lk   = elk;
        e.err  = eerr;
        sb.push_back(e);
        if (eerr) exp_err_total++;
        tick(HALF);
    endtask

    // Frame of nbits starting with a 1->0 ws edge, ws high from bit hi_at.
    // locked is expected as lk except from err_bit onward (err_bit<0: no error).
    task automatic send_frame(input int nbits, input int hi_at, input logic lk, input int err_bit);
        for (int k = 0; k < nbits; k++)
            bit_rise(k >= hi_at, k, k == 0,
                     (err_bit >= 0 && k >= err_bit) ? 1'b0 : lk, k == err_bit);
    endtask

    // Bits while unaligned: counter runs freely from first_posn
    task automatic free_run(input int nbits, input int hi_at, input int first_posn);
        for (int k = 0; k < nbits; k++)
            bit_rise(k >= hi_at, first_posn + k, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard consumer: compares each DUT sck_rise cycle with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge ck);
            #1;
            if (error) n_err_pulses++;
            if (sck_fall) n_fall_seen++;
            if (sck_rise) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rise", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("posn", frame_posn, e.posn);
                    check("ws", ws, e.ws);
                    check("frame_start", frame_start, e.fs);
                    check("locked", locked, e.lk);
                    check("error", error, e.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   first_hi;
        int   width;
        int   err_before;
        logic lk_after;
        exp_t e;

        // Reset state
        sck_in = 1'b0;
        ws_in  = 1'b1;
        rst    = 1'b1;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(1);
        check_outputs_zero("post_reset");

        // Edge latency and strobe width from a single sck rise
        tick(HALF);
        sck_in = 1'b1;
        e.posn = 6'd1; e.ws = 1'b1; e.fs = 1'b0; e.lk = 1'b0; e.err = 1'b0;
        sb.push_back(e);
        first_hi = 0;
        width    = 0;
        for (int c = 1; c <= 2 * HALF; c++) begin
            @(posedge ck);
            #1;
            if (sck_rise) begin
                if (first_hi == 0) first_hi = c;
                width++;
            end
        end
        check("rise_latency", first_hi, SS + 2);
        check("rise_width", width, 1);
        free_run(3, 0, 2);

        // Lock from a well-formed stream: align, one good frame, lock on the next
        send_frame(64, 32, 1'b0, -1);
        send_frame(64, 32, 1'b0, -1);
        for (int f = 0; f < 9; f++) send_frame(64, 32, 1'b1, -1);

        // Short frame: violation on the early 1->0 edge, relock after two good frames
        send_frame(48, 32, 1'b1, -1);
        send_frame(64, 32, 1'b1, 0);
        send_frame(64, 32, 1'b0, -1);
        send_frame(64, 32, 1'b1, -1);

        // Early 0->1 at bit 30: violation there, resync on next 1->0, then relock
        send_frame(64, 30, 1'b1, 30);
        send_frame(64, 32, 1'b0, -1);
        send_frame(64, 32, 1'b0, -1);
        send_frame(64, 32, 1'b1, -1);

        // Stopped sck
        err_before = n_err_pulses;
        tick(300);
`ifdef I2S_FOLLOWER_TIMEOUT_EN
        check("idle_error_pulses", n_err_pulses - err_before, 1);
        check("idle_locked", locked, 0);
        exp_err_total++;
        lk_after = 1'b0;
`else
        check("idle_error_pulses", n_err_pulses - err_before, 0);
        check("idle_locked", locked, 1);
        lk_after = 1'b1;
`endif
        send_frame(64, 32, lk_after, -1);

        // Reset mid-frame at frame_posn 17
        send_frame(18, 32, lk_after, -1);
        check("posn_before_rst", frame_posn, 17);
        sck_in = 1'b0;
        rst    = 1'b1;
        tick(1);
        check_outputs_zero("midframe_reset");
        rst = 1'b0;
        tick(HALF);
        free_run(46, 14, 1);
        send_frame(64, 32, 1'b0, -1);
        send_frame(64, 32, 1'b0, -1);
        send_frame(64, 32, 1'b1, -1);

        tick(20);
        check("sb_drain", sb.size(), 0);
        check("fall_count", n_fall_seen, n_fall_drv);
        check("error_total", n_err_pulses, exp_err_total);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
